// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store request per handshake on a word-organised RAM.
// Optional DMEM_ALIGN_ERR_EN: flag misaligned/illegal requests instead of forcing alignment.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [3:0]            req_ctrl_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = $clog2(DEPTH);

  localparam logic [3:0] MEM_IDLE = 4'd0;
  localparam logic [3:0] MEM_RB   = 4'd1;
  localparam logic [3:0] MEM_RBU  = 4'd2;
  localparam logic [3:0] MEM_RH   = 4'd3;
  localparam logic [3:0] MEM_RHU  = 4'd4;
  localparam logic [3:0] MEM_RW   = 4'd5;
  localparam logic [3:0] MEM_RWU  = 4'd6;
  localparam logic [3:0] MEM_RD   = 4'd7;
  localparam logic [3:0] MEM_WB   = 4'd8;
  localparam logic [3:0] MEM_WH   = 4'd9;
  localparam logic [3:0] MEM_WW   = 4'd10;
  localparam logic [3:0] MEM_WD   = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            ctrl_q;
  logic [OFFW-1:0]       off_q;
  logic [IDXW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_d;
  logic                  exec;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic unused_addr;
  assign unused_addr = ^req_addr_i[ADDR_WIDTH-1:OFFW+IDXW];

  // With zero wait cycles the access executes on the accepting edge, so the
  // live request is used; otherwise the captured copy is.
  logic [3:0]            op_ctrl;
  logic [OFFW-1:0]       op_off;
  logic [IDXW-1:0]       op_idx;
  logic [DATA_WIDTH-1:0] op_wdata;

  always_comb begin
    if (state_q == S_IDLE) begin
      op_ctrl  = req_ctrl_i;
      op_off   = req_addr_i[OFFW-1:0];
      op_idx   = req_addr_i[OFFW +: IDXW];
      op_wdata = req_wdata_i;
    end else begin
      op_ctrl  = ctrl_q;
      op_off   = off_q;
      op_idx   = idx_q;
      op_wdata = wdata_q;
    end
  end

  logic       legal, is_load, is_store, sgn;
  logic [1:0] sz;

  always_comb begin
    legal    = 1'b1;
    is_load  = 1'b0;
    is_store = 1'b0;
    sgn      = 1'b0;
    sz       = 2'd0;
    case (op_ctrl)
      MEM_IDLE: ;
      MEM_RB:  begin is_load = 1'b1; sgn = 1'b1; sz = 2'd0; end
      MEM_RBU: begin is_load = 1'b1;             sz = 2'd0; end
      MEM_RH:  begin is_load = 1'b1; sgn = 1'b1; sz = 2'd1; end
      MEM_RHU: begin is_load = 1'b1;             sz = 2'd1; end
      MEM_RW:  begin is_load = 1'b1; sgn = 1'b1; sz = 2'd2; end
      MEM_RWU: begin is_load = 1'b1; sz = 2'd2; legal = (DATA_WIDTH == 64); end
      MEM_RD:  begin is_load = 1'b1; sz = 2'd3; legal = (DATA_WIDTH == 64); end
      MEM_WB:  begin is_store = 1'b1; sz = 2'd0; end
      MEM_WH:  begin is_store = 1'b1; sz = 2'd1; end
      MEM_WW:  begin is_store = 1'b1; sz = 2'd2; end
      MEM_WD:  begin is_store = 1'b1; sz = 2'd3; legal = (DATA_WIDTH == 64); end
      default: legal = 1'b0;
    endcase
  end

  logic [OFFW-1:0] sz_mask, eff_off;
  logic            ok;

  assign sz_mask = OFFW'((4'd1 << sz) - 4'd1);

`ifdef DMEM_ALIGN_ERR_EN
  assign ok      = legal && ((op_off & sz_mask) == '0);
  assign eff_off = op_off;
`else
  assign ok      = legal;
  assign eff_off = op_off & ~sz_mask;
`endif

  // Load formatting: bring the addressed lane down, then shift up and back to extend.
  logic [DATA_WIDTH-1:0] word_rd, shifted, left, fmt;
  logic [6:0]            shamt;

  always_comb begin
    word_rd = mem_q[op_idx];
    shifted = word_rd >> {eff_off, 3'b000};
    shamt   = 7'(DATA_WIDTH - (8 << sz));
    left    = shifted << shamt;
    fmt     = sgn ? DATA_WIDTH'($signed(left) >>> shamt) : (left >> shamt);
  end

  logic [7:0]            be_base;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wshift;

  always_comb begin
    case (sz)
      2'd0:    be_base = 8'h01;
      2'd1:    be_base = 8'h03;
      2'd2:    be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
    be     = NB'(be_base) << eff_off;
    wshift = op_wdata << {eff_off, 3'b000};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign exec    = (state_d == S_RESP) && (state_q != S_RESP);
  assign rdata_d = (is_load && ok) ? fmt : '0;
  assign err_d   = !ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      off_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req_valid_i) begin
        ctrl_q  <= req_ctrl_i;
        off_q   <= req_addr_i[OFFW-1:0];
        idx_q   <= req_addr_i[OFFW +: IDXW];
        wdata_q <= req_wdata_i;
      end
      if (exec) rdata_q <= rdata_d;
    end
  end

`ifdef DMEM_ALIGN_ERR_EN
  logic err_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     err_q <= 1'b0;
    else if (exec) err_q <= err_d;
  end
  assign rsp_err_o = err_q;
`else
  logic unused_err;
  assign unused_err = err_d;
  assign rsp_err_o  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (exec && is_store && ok && !rst_i) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) mem_q[op_idx][b*8 +: 8] <= wshift[b*8 +: 8];
      end
    end
  end

  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a zero-wait instance, hand sequences on a two-wait instance.
module tb_dmem_responder;

  localparam logic [3:0] C_IDLE = 4'd0,  C_RB = 4'd1,  C_RBU = 4'd2, C_RH = 4'd3;
  localparam logic [3:0] C_RHU  = 4'd4,  C_RW = 4'd5,  C_RWU = 4'd6;
  localparam logic [3:0] C_WB   = 4'd8,  C_WH = 4'd9,  C_WW  = 4'd10;

`ifdef DMEM_ALIGN_ERR_EN
  localparam bit AE = 1'b1;
`else
  localparam bit AE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld;
  logic [3:0]  ctrl;
  logic [31:0] addr, wdata;
  logic        rsp_rdy;
  logic        rq_rdy [2];
  logic        rv     [2];
  logic        re     [2];
  logic [31:0] rd     [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(vld[0]), .req_ready_o(rq_rdy[0]),
    .req_ctrl_i(ctrl), .req_addr_i(addr), .req_wdata_i(wdata),
    .rsp_valid_o(rv[0]), .rsp_ready_i(rsp_rdy), .rsp_rdata_o(rd[0]), .rsp_err_o(re[0]));

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(vld[1]), .req_ready_o(rq_rdy[1]),
    .req_ctrl_i(ctrl), .req_addr_i(addr), .req_wdata_i(wdata),
    .rsp_valid_o(rv[1]), .rsp_ready_i(rsp_rdy), .rsp_rdata_o(rd[1]), .rsp_err_o(re[1]));

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accepts one request on instance w and waits for rsp_valid; lat counts edges from acceptance.
  task automatic issue(input int w, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] d, output int lat);
    @(negedge clk);
    ctrl = c; addr = a; wdata = d; vld[w] = 1'b1;
    for (int i = 0; i < 20 && !rq_rdy[w]; i++) @(negedge clk);
    @(posedge clk); #1;
    vld[w] = 1'b0;
    lat = 1;
    while (!rv[w] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rv[w]) begin
      n_vec++; n_bad++;
      $display("FAIL timeout inst%0d: got no rsp_valid expected rsp_valid within 40 cycles", w);
    end
  endtask

  task automatic txn(input int w, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] r, output logic e);
    int lat;
    rsp_rdy = 1'b1;
    issue(w, c, a, d, lat);
    r = rd[w];
    e = re[w];
    @(posedge clk); #1;
  endtask

  vec_t        tbl [18];
  logic [31:0] r, held;
  logic        e;
  int          lat;

  initial begin
    tbl[0]  = '{C_WW,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{C_RB,  32'h11,   32'h0,        32'hFFFFFFBE, 1'b0};
    tbl[2]  = '{C_RBU, 32'h13,   32'h0,        32'h000000DE, 1'b0};
    tbl[3]  = '{C_RH,  32'h12,   32'h0,        32'hFFFFDEAD, 1'b0};
    tbl[4]  = '{C_RHU, 32'h10,   32'h0,        32'h0000BEEF, 1'b0};
    tbl[5]  = '{C_WB,  32'h12,   32'h00000055, 32'h0,        1'b0};
    tbl[6]  = '{C_RW,  32'h10,   32'h0,        32'hDE55BEEF, 1'b0};
    tbl[7]  = '{C_WH,  32'h10,   32'h00001234, 32'h0,        1'b0};
    tbl[8]  = '{C_RW,  32'h10,   32'h0,        32'hDE551234, 1'b0};
    tbl[9]  = '{C_WW,  32'h1000, 32'hA5A5A5A5, 32'h0,        1'b0};
    tbl[10] = '{C_RW,  32'h0,    32'h0,        32'hA5A5A5A5, 1'b0};
    tbl[11] = '{C_RW,  32'h11,   32'h0,        AE ? 32'h0 : 32'hDE551234, AE};
    tbl[12] = '{C_WW,  32'h12,   32'hFFFFFFFF, 32'h0,        AE};
    tbl[13] = '{C_RW,  32'h10,   32'h0,        AE ? 32'hDE551234 : 32'hFFFFFFFF, 1'b0};
    tbl[14] = '{4'hF,  32'h10,   32'h0,        32'h0,        AE};
    tbl[15] = '{C_RWU, 32'h10,   32'h0,        32'h0,        AE};
    tbl[16] = '{C_IDLE,32'h10,   32'h0,        32'h0,        1'b0};
    tbl[17] = '{C_RB,  32'h10,   32'h0,        AE ? 32'h00000034 : 32'hFFFFFFFF, 1'b0};

    rst = 1'b1; vld = '0; ctrl = '0; addr = '0; wdata = '0; rsp_rdy = 1'b1;
    @(negedge clk); @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("reset req_ready%0d", w), 32'(rq_rdy[w]), 32'h1);
      check($sformatf("reset rsp_valid%0d", w), 32'(rv[w]), 32'h0);
      check($sformatf("reset rdata%0d", w), rd[w], 32'h0);
      check($sformatf("reset err%0d", w), 32'(re[w]), 32'h0);
    end
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      txn(0, tbl[i].c, tbl[i].a, tbl[i].d, r, e);
      check($sformatf("vec%0d rdata", i), r, tbl[i].exp_rd);
      check($sformatf("vec%0d err", i), 32'(e), 32'(tbl[i].exp_err));
    end

    rsp_rdy = 1'b1;
    issue(1, C_WW, 32'h40, 32'h12345678, lat);
    check("wait2 store latency", 32'(lat), 32'd3);
    @(posedge clk); #1;

    rsp_rdy = 1'b0;
    issue(1, C_RW, 32'h40, 32'h0, lat);
    check("wait2 load latency", 32'(lat), 32'd3);
    held = rd[1];
    check("wait2 load rdata", held, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d valid", i), 32'(rv[1]), 32'h1);
      check($sformatf("bp%0d rdata", i), rd[1], held);
      check($sformatf("bp%0d req_ready", i), 32'(rq_rdy[1]), 32'h0);
    end
    @(negedge clk);
    rsp_rdy = 1'b1;
    ctrl = C_RB; addr = 32'h40; wdata = '0; vld[1] = 1'b1;
    @(posedge clk); #1;
    check("handshake valid drop", 32'(rv[1]), 32'h0);
    check("handshake req_ready", 32'(rq_rdy[1]), 32'h1);
    @(posedge clk); #1;
    vld[1] = 1'b0;
    check("next accepted", 32'(rq_rdy[1]), 32'h0);
    lat = 1;
    while (!rv[1] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("next latency", 32'(lat), 32'd3);
    check("next rdata", rd[1], 32'h00000078);
    @(posedge clk); #1;

    txn(1, C_WW, 32'h20, 32'hCAFEF00D, r, e);
    @(negedge clk);
    ctrl = C_WW; addr = 32'h20; wdata = 32'h11111111; vld[1] = 1'b1;
    @(posedge clk); #1;
    vld[1] = 1'b0;
    check("abort in wait", 32'(rq_rdy[1]), 32'h0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("abort rsp_valid", 32'(rv[1]), 32'h0);
    check("abort req_ready", 32'(rq_rdy[1]), 32'h1);
    txn(1, C_RW, 32'h20, 32'h0, r, e);
    check("abort store dropped", r, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the core's load/store interface.
- Accepts one request per handshake, encoded with the core's MEM_* control codes (MEM_IDLE, MEM_RB..MEM_RD, MEM_WB..MEM_WD).
- Performs the access on an internal word-organised RAM and returns formatted load data (sign/zero-extended) over a valid/ready response channel.
- Serves as the DMEM model behind the core's MEM stage in simulation and on FPGA.

Parameters:
- DATA_WIDTH, 32, data path width in bits; 32 or 64 only.
- ADDR_WIDTH, 32, request address width in bits.
- DEPTH, 1024, number of DATA_WIDTH words; power of two.
- WAIT_CYCLES, 0, extra cycles between acceptance and response, 0..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  responder can accept a request.
- req_ctrl_i  in  4  MEM_* control code.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0], ...).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  requester accepts the response.
- rsp_rdata_o  out  DATA_WIDTH  formatted load data; 0 for stores, MEM_IDLE and errored requests.
- rsp_err_o  out  1  request failed (see Optional Feature).

Behaviour:
- Interface:
  - Clock and reset are one clock, clk_i, with asynchronous active-high reset rst_i.
  - Reset forces state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, wait counter 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready_o=1. On req_valid_i&&req_ready_o the ctrl, addr and wdata are captured. Next state is WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else RESP.
  - WAIT: req_ready_o=0. Counter decrements each cycle; at 0 the next state is RESP.
  - On entry to RESP (the same edge), the access executes: stores write the RAM with byte-lane masking, loads read and format.
  - RESP: rsp_valid_o=1, with rdata and err stable. If rsp_ready_i=1, go to IDLE. Otherwise hold indefinitely.
  - No new request is accepted in the cycle the response completes; req_ready_o rises the cycle after.
- Latency: rsp_valid_o asserts WAIT_CYCLES+1 cycles after the accepting edge. Throughput is one request per WAIT_CYCLES+2 cycles with rsp_ready_i tied high.
- Addressing:
  - Byte offset = addr[$clog2(DATA_WIDTH/8)-1:0].
  - Word index = next $clog2(DEPTH) bits. Upper address bits are ignored, so accesses wrap modulo DEPTH words.
- Loads:
  - RB/RBU extract the byte at the offset, then sign-/zero-extend it.
  - RH/RHU and RW/RWU do the same for half-words and words.
  - RD returns the full word.
  - When DATA_WIDTH=32, RW returns the full word unextended.
- Stores: WB/WH/WW/WD write req_wdata_i low bytes into the lanes at the offset; other lanes are unchanged.
- MEM_IDLE: accepted; returns rdata=0, err=0; no RAM effect.
- Illegal requests:
  - Codes 1100-1111 are always illegal.
  - When DATA_WIDTH=32, RWU, RD and WD are also illegal.
  - Illegal requests behave as MEM_IDLE, plus err as described under Optional Feature.
- Reset mid-operation: the transaction is aborted. A store captured but not yet in RESP is not committed.

Optional Feature:
- Macro: DMEM_ALIGN_ERR_EN.
- Defined:
  - A misaligned access (offset not a multiple of the access size) or an illegal code returns rsp_err_o=1 and rsp_rdata_o=0.
  - The RAM is not modified.
- Undefined:
  - Offset bits below the access size are cleared (forced alignment).
  - Illegal codes return err=0.
  - rsp_err_o is tied 0.

Test Plan:
- DATA_WIDTH=32, WAIT_CYCLES=0: WW 0xDEADBEEF @0x10, then RB @0x11 -> 0xFFFFFFBE; RBU @0x13 -> 0x000000DE; RH @0x12 -> 0xFFFFDEAD; RHU @0x10 -> 0x0000BEEF.
- After the above, WB wdata 0x00000055 @0x12, then RW @0x10 -> 0xDE55BEEF. WH 0x1234 @0x10, then RW -> 0xDE551234.
- Latency/backpressure, WAIT_CYCLES=2:
  - rsp_valid_o rises 3 cycles after acceptance.
  - Holding rsp_ready_i=0 for 5 cycles keeps valid/rdata stable and req_ready_o=0.
  - A new request is accepted 1 cycle after the response handshake.
- Wrap, DEPTH=1024: WW 0xA5A5A5A5 @0x1000, then RW @0x0 -> 0xA5A5A5A5.
- With DMEM_ALIGN_ERR_EN: RW @0x11 -> err=1, rdata=0. WW 0xFFFFFFFF @0x12 -> err=1, and RW @0x10 is unchanged. ctrl=4'b1111 -> err=1.
- rst_i pulsed while in WAIT with a pending WW 0x11111111 @0x20 -> rsp_valid_o=0, req_ready_o=1 after reset, and RW @0x20 returns the prior value.
